// File: rtl/score_scheduler.sv
// rtl/score_scheduler.sv - round-robin point-event scheduler driving a 12-bit saturating +1 score counter
module score_scheduler #(
    parameter int NREQ = 3,
    parameter int VW   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           game_state,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*VW-1:0]   req_val,
    input  logic [11:0]          score_in,
    output logic                 add,
    output logic                 clr,
    output logic [NREQ-1:0]      gnt,
    output logic                 busy
);

    localparam int RW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {
        S_WAIT  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t                     state_q, state_d;
    logic [VW-1:0]              cnt_q, cnt_d;
    logic [NREQ-1:0]            pend_q, pend_d;
    logic [NREQ-1:0][VW-1:0]    pval_q, pval_d;
    logic [NREQ-1:0]            gnt_q, gnt_d;
    logic [RW-1:0]              rr_q, rr_d;
    logic [1:0]                 prev_state_q;

    logic                       play, new_game, saturated;
    logic [RW-1:0]              sel;
    logic                       sel_found;
    logic [NREQ-1:0]            grant_mask;
    logic [VW:0]                sum;

    assign play      = (game_state == 2'b01);
    assign new_game  = play && (prev_state_q == 2'b00);
    assign saturated = (score_in == 12'hFFF);
    // clr is combinational, so it must not leak out while reset is held
    assign clr       = new_game && reset;
    assign busy      = (state_q == S_BURST);
    assign add       = busy && play && !saturated;
    assign gnt       = gnt_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pend_d     = pend_q;
        pval_d     = pval_q;
        gnt_d      = gnt_q;
        rr_d       = rr_q;
        grant_mask = '0;
        sum        = '0;
        sel        = '0;
        sel_found  = 1'b0;

        // first pending source after the last granted one
        for (int k = 1; k <= NREQ; k++) begin
            if (!sel_found && pend_q[RW'((int'(rr_q) + k) % NREQ)]) begin
                sel       = RW'((int'(rr_q) + k) % NREQ);
                sel_found = 1'b1;
            end
        end

        if (new_game || !play) begin
            state_d = S_WAIT;
            cnt_d   = '0;
            gnt_d   = '0;
            pend_d  = '0;
        end else begin
            case (state_q)
                S_WAIT: begin
                    if (sel_found) begin
                        state_d    = S_BURST;
                        cnt_d      = pval_q[sel];
                        gnt_d      = NREQ'(1) << sel;
                        rr_d       = sel;
                        grant_mask = NREQ'(1) << sel;
                    end
                end
                S_BURST: begin
                    if (saturated) begin
                        state_d = S_WAIT;
                        cnt_d   = '0;
                        gnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - VW'(1);
                        if (cnt_q == VW'(1)) begin
                            state_d = S_WAIT;
                            gnt_d   = '0;
                        end
                    end
                end
                default: state_d = S_WAIT;
            endcase

            // a source granted on this edge starts a fresh pending value
            for (int i = 0; i < NREQ; i++) begin
                if (req[i] && (req_val[i*VW +: VW] != '0)) begin
                    if (pend_q[i] && !grant_mask[i]) begin
                        sum       = {1'b0, pval_q[i]} + {1'b0, req_val[i*VW +: VW]};
                        pval_d[i] = sum[VW] ? '1 : sum[VW-1:0];
                    end else begin
                        pval_d[i] = req_val[i*VW +: VW];
                    end
                    pend_d[i] = 1'b1;
                end else if (grant_mask[i]) begin
                    pend_d[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_WAIT;
            cnt_q        <= '0;
            pend_q       <= '0;
            pval_q       <= '0;
            gnt_q        <= '0;
            rr_q         <= RW'(NREQ - 1);
            prev_state_q <= 2'b00;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pend_q       <= pend_d;
            pval_q       <= pval_d;
            gnt_q        <= gnt_d;
            rr_q         <= rr_d;
            prev_state_q <= game_state;
        end
    end

endmodule
